// File: rtl/vx_lane_serializer_pkg.sv
// Shared definitions for the lane serializer: lane-index width helper,
// default lane index type and performance counter width.
package vx_lane_serializer_pkg;

  // Width of a lane index: ceil(log2(n)), never less than 1.
  function automatic int unsigned lane_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

  localparam int unsigned DEFAULT_NUM_LANES = 4;
  localparam int unsigned DEFAULT_LANEW     = lane_w(DEFAULT_NUM_LANES);

  typedef logic [DEFAULT_LANEW-1:0] lane_idx_t;

  localparam int unsigned PERF_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } ser_state_t;

endpackage

// File: rtl/vx_lane_find_first.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of
// i_bits plus a flag saying whether any bit is set.
module vx_lane_find_first
  import vx_lane_serializer_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = lane_w(N)
) (
  input  logic [N-1:0]    i_bits,
  output logic [IDXW-1:0] o_index,
  output logic            o_valid
);

  // Scan from the top down so the lowest set bit is the one left standing.
  always_comb begin
    o_index = '0;
    o_valid = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (i_bits[i-1]) begin
        o_index = IDXW'(i - 1);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_lane_serializer.sv
// Lane serializer: accepts one multi-lane word with a lane-valid mask and
// emits the active lanes one per cycle, lowest index first, on a narrow
// valid/ready stream. Back-to-back words are accepted on the last-lane fire.
// Optional macro VX_LANE_SERIALIZER_PERF_EN adds stall and word counters.
module vx_lane_serializer
  import vx_lane_serializer_pkg::*;
#(
  parameter  int unsigned NUM_LANES = 4,
  parameter  int unsigned DATAW     = 32,
  localparam int unsigned LANEW     = lane_w(NUM_LANES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [NUM_LANES*DATAW-1:0] data_in,
  input  logic [NUM_LANES-1:0]       mask_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [DATAW-1:0]           data_out,
  output logic [LANEW-1:0]           lane_out,
  output logic                       last_out
`ifdef VX_LANE_SERIALIZER_PERF_EN
  ,
  output logic [PERF_W-1:0]          perf_stall_cycles,
  output logic [PERF_W-1:0]          perf_words
`endif
);

  ser_state_t                 r_state;
  logic [NUM_LANES*DATAW-1:0] r_data;
  logic [NUM_LANES-1:0]       r_rem;

  logic [LANEW-1:0]           w_cur;
  logic                       w_cur_valid;
  logic [NUM_LANES-1:0]       w_rem_rest;
  logic                       w_fire;
  logic                       w_accept;
  logic                       w_load;

  vx_lane_find_first #(
    .N    (NUM_LANES),
    .IDXW (LANEW)
  ) u_find_first (
    .i_bits  (r_rem),
    .o_index (w_cur),
    .o_valid (w_cur_valid)
  );

  // Handshake and current-lane decode; rem_r is never zero while busy.
  always_comb begin
    w_rem_rest = r_rem & (r_rem - 1'b1);
    last_out   = (w_rem_rest == '0);
    lane_out   = w_cur;
    valid_out  = (r_state == S_BUSY) && w_cur_valid;
    w_fire     = valid_out && ready_out;
    ready_in   = (r_state == S_IDLE) || (w_fire && last_out);
    w_accept   = valid_in && ready_in;
    w_load     = w_accept && (mask_in != '0);
  end

  // Select the data of the current lane.
  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (w_cur == LANEW'(i)) begin
        data_out = r_data[i*DATAW +: DATAW];
      end
    end
  end

  // Word buffer: loaded on a non-empty accept only, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data <= data_in;
    end
  end

  // Control FSM: a non-empty accept wins over the last-lane fire so the
  // next word follows without a bubble; a zero-mask word just drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else if (w_load) begin
      r_state <= S_BUSY;
      r_rem   <= mask_in;
    end else if (w_fire) begin
      r_rem <= w_rem_rest;
      if (last_out) begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef VX_LANE_SERIALIZER_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_words;

  // Stall-cycle and accepted-word counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_words <= '0;
    end else begin
      if (valid_out && !ready_out) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
      if (w_accept) begin
        r_perf_words <= r_perf_words + 1'b1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_words        = r_perf_words;
`endif

endmodule

// File: doc/vx_lane_serializer.md
Name: vx_lane_serializer

Overview:
- Downstream consumer of an elastic buffer's output.
- Accepts one wide multi-lane word per handshake together with a lane-valid mask.
- Emits only the active lanes, one per cycle, lowest lane index first, on a narrow valid/ready stream.
- Used wherever a per-warp/per-thread request bundle must be funneled into a single-lane pipeline (e.g. a memory port or scalar unit).

Parameters:
- NUM_LANES, 4: lanes per input word; must be >= 2.
- DATAW, 32: bits per lane.
- LANEW, derived: ceil(log2(NUM_LANES)); lane index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  input word valid.
- ready_in  out  1  input word accepted when valid_in && ready_in.
- data_in  in  NUM_LANES*DATAW  lane i occupies bits [i*DATAW +: DATAW].
- mask_in  in  NUM_LANES  lane-active mask.
- valid_out  out  1  output lane valid.
- ready_out  in  1  downstream ready.
- data_out  out  DATAW  current lane data.
- lane_out  out  LANEW  index of current lane.
- last_out  out  1  current lane is the last active lane of its word.

Clock and reset:
- One clock, clk. Reset is synchronous and active-high on port reset; this is already decided.

Behaviour:
- State: busy flag; data_r (NUM_LANES*DATAW); rem_r (NUM_LANES, lanes still to emit).
- Reset values: busy=0, rem_r=0, valid_out=0, ready_in=1 (combinational from busy). data_r is not reset. data_out, lane_out and last_out are don't-care while valid_out=0.
- Two states:
  - IDLE (busy=0).
  - BUSY (busy=1, rem_r != 0 always holds).
- Current lane: cur = index of lowest set bit of rem_r.
  - data_out = data_r[cur].
  - lane_out = cur.
  - last_out = (rem_r with bit cur cleared) == 0.
- valid_out = busy.
- ready_in = ~busy || (valid_out && ready_out && last_out). This gives back-to-back words with no bubble.
- Accept with mask_in != 0:
  - data_r <= data_in, rem_r <= mask_in, busy <= 1.
  - First valid_out appears the cycle after acceptance (latency 1).
- Accept with mask_in == 0:
  - Word is consumed and dropped; nothing is emitted; busy is unchanged.
  - This is legal in IDLE, and in BUSY only on the last-lane fire cycle (the word is then dropped and busy falls to 0).
- Output fire (valid_out && ready_out):
  - Clear bit cur in rem_r.
  - If last_out and there is no simultaneous non-zero accept, busy <= 0.
  - Simultaneous last-fire and accept: the new word loads and busy stays 1.
- Stall (valid_out && ~ready_out): all outputs and state hold stable (valid/ready protocol; valid_out never drops without a fire).
- Throughput: popcount(mask_in) cycles per word. A full mask with NUM_LANES lanes gives N cycles.
- Reset mid-operation: the word in flight is discarded, with no partial emission after reset.
- Input stability: data_in and mask_in are sampled only on the accept cycle.

Optional Feature:
- Macro: VX_LANE_SERIALIZER_PERF_EN.
- When defined, add two output ports:
  - perf_stall_cycles, 32 bits: increments each cycle valid_out && ~ready_out.
  - perf_words, 32 bits: increments on each accept, including zero-mask words.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, neither port nor counter exists; the functional behaviour is identical.

Decomposition:
- Shared package vx_lane_serializer_pkg holds:
  - LANEW computation helper.
  - Lane index typedef.
  - Perf counter width constant (32).
- Sub-module vx_lane_find_first: combinational lowest-set-bit encoder, NUM_LANES in, LANEW index plus valid out. It computes cur and is reusable elsewhere.
- last_out is derived in the top level from rem_r & (rem_r - 1).

Test Plan:
1. NUM_LANES=4, DATAW=32. Input mask 4'b1111, data {D,C,B,A}, ready_out=1 → 4 outputs on consecutive cycles starting the cycle after acceptance: lane 0..3, data A,B,C,D, last_out only on lane 3. ready_in=1 on the lane-3 cycle.
2. Mask 4'b1010 → two outputs: lane 1 then lane 3; last_out=1 on lane 3; lanes 0/2 never appear.
3. Mask 4'b0000 accepted while IDLE → ready_in stays 1, valid_out never asserts. A following mask 4'b0001 emits lane 0 with last_out=1.
4. Back-to-back words (mask 4'b0011, then 4'b1000, valid_in held) → outputs lane0, lane1(last), lane3(last) on 3 consecutive cycles, with no bubble.
5. Hold ready_out=0 for 5 cycles mid-word → data_out, lane_out and last_out stay stable and ready_in stays 0. With the PERF macro defined, perf_stall_cycles increases by exactly 5.
6. Assert reset while BUSY with 2 lanes remaining → next cycle valid_out=0, ready_in=1, and no residual lanes are emitted afterwards.
